mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (16), meaning memory address width.
REQ-002 SHALL have parameter REG_WIDTH, default `REG_WIDTH (8), meaning data width.
REQ-003 SHALL have parameter DMA_TRIG, default 16'h4014, meaning the address whose write starts sprite DMA.
REQ-004 SHALL have parameter OAM_DATA, default 16'h2004, meaning the DMA write destination.
REQ-005 SHALL be clocked by phi1 (input, 1): the only clock; all state updates on its rising edge.
REQ-006 SHALL have reset (input, 1): asynchronous, active-high.
REQ-007 SHALL have f_req (input, 1): fetcher read request.
REQ-008 SHALL have f_addr (input, ADDR_WIDTH): fetcher read address.
REQ-009 SHALL have e_req (input, 1): execute-unit request.
REQ-010 SHALL have e_wr (input, 1): execute-unit access is a write.
REQ-011 SHALL have e_addr (input, ADDR_WIDTH): execute-unit address.
REQ-012 SHALL have e_wdata (input, REG_WIDTH): execute-unit write data.
REQ-013 SHALL have mem_rdata (input, REG_WIDTH): asynchronous read data from memory.
REQ-014 SHALL have mem_addr (output, ADDR_WIDTH): registered shared bus address.
REQ-015 SHALL have mem_wr (output, 1): registered bus write strobe.
REQ-016 SHALL have mem_wdata (output, REG_WIDTH): registered bus write data.
REQ-017 SHALL have f_gnt and e_gnt (outputs, 1 each): registered grants, one-hot or zero.
REQ-018 SHALL have cpu_stall (output, 1): high while DMA owns the bus.
REQ-019 SHALL have dma_busy (output, 1): high in any non-IDLE state.

Function
REQ-020 SHALL implement states IDLE, ALIGN, ALIGN2, DMA_RD, DMA_WR.
REQ-021 SHALL keep a parity flop, odd, cleared by reset and toggling every phi1 edge.
REQ-022 In IDLE, on each edge, SHALL grant e if e_req, else f if f_req, else nobody; arbitration per cycle, no lock.
REQ-023 A grant issued at edge N SHALL drive mem_addr/mem_wr/mem_wdata from the winner for the cycle after N; read data on mem_rdata is valid in that cycle; the requester samples it at edge N+1.
REQ-024 A losing requester SHALL receive gnt=0 and must hold req; no request is queued internally.
REQ-025 With no grant, SHALL drive mem_addr=0, mem_wr=0, mem_wdata=0.
REQ-026 The fetcher SHALL never be given mem_wr=1.
REQ-027 An e write with e_addr==DMA_TRIG in IDLE SHALL latch page=e_wdata, assert e_gnt, keep mem_wr=0 (not forwarded), and enter ALIGN.
REQ-028 ALIGN SHALL last one cycle; if odd=1 during ALIGN, go to ALIGN2 (one extra cycle), else go to DMA_RD.
REQ-029 DMA_RD SHALL drive mem_addr={page, idx}, mem_wr=0; the next state is DMA_WR.
REQ-030 Entering DMA_WR SHALL capture mem_rdata into dma_data, drive mem_addr=OAM_DATA, mem_wr=1, mem_wdata=dma_data.
REQ-031 idx (8-bit) SHALL increment on leaving DMA_WR; when idx wraps 255->0, the next state is IDLE, else DMA_RD.
REQ-032 DMA SHALL stall for a total of 513 cycles (even start) or 514 cycles (odd start), counted from the first ALIGN cycle.
REQ-033 cpu_stall and dma_busy SHALL be high from ALIGN through the final DMA_WR, and low on the first IDLE cycle.
REQ-034 During DMA, f_gnt=e_gnt=0 regardless of requests; held requests are arbitrated normally on the first IDLE edge.
REQ-035 page=8'hFF SHALL read 16'hFF00..16'hFFFF; address arithmetic SHALL not carry into page.
REQ-036 e reads of DMA_TRIG SHALL be ordinary reads and SHALL not start DMA.

Reset
REQ-037 While reset is high (asynchronous, even mid-DMA), SHALL force IDLE, odd=0, idx=0, page=0, dma_data=0, all outputs 0.
REQ-038 The first edge after reset deasserts SHALL arbitrate normally.

Verification
REQ-039 f_req=1, f_addr=16'h8000, e_req=0 -> next cycle f_gnt=1, mem_addr=16'h8000, mem_wr=0.
REQ-040 f_req=1 and e_req=1 (e_wr=1, e_addr=16'h0010, e_wdata=8'h5A) simultaneously -> e_gnt=1, f_gnt=0, mem_wr=1, mem_wdata=8'h5A; on the next edge f wins.
REQ-041 e write 8'h02 to 16'h4014 with ALIGN on an even cycle -> mem_wr=0; cpu_stall high for 513 cycles; bus alternates 16'h0200+i read / 16'h2004 write of the byte read; the last write is from 16'h02FF.
REQ-042 Same trigger with ALIGN on an odd cycle -> cpu_stall high for 514 cycles; the first DMA read occurs one cycle later.
REQ-043 reset pulsed at DMA idx=8'h40 -> outputs immediately 0, state IDLE; a pending f_req is granted on the first edge after release.
REQ-044 page=8'hFF DMA -> final read address 16'hFFFF, then IDLE, with no access to 16'h0000.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared-bus arbiter between a fetcher and an execute unit, with a sprite DMA
// engine that copies a 256-byte page to the OAM data port when DMA_TRIG is written.
module mem_arbiter #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    REG_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] DMA_TRIG   = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA   = 16'h2004
) (
    input  logic                  phi1,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    input  logic                  e_req,
    input  logic                  e_wr,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [REG_WIDTH-1:0]  e_wdata,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic                  f_gnt,
    output logic                  e_gnt,
    output logic                  cpu_stall,
    output logic                  dma_busy
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ALIGN2,
        DMA_RD,
        DMA_WR
    } state_t;

    state_t               state;
    logic                 odd;
    logic [7:0]           idx;
    logic [7:0]           idx_next;
    logic [REG_WIDTH-1:0] page;
    logic [REG_WIDTH-1:0] dma_data;
    logic [REG_WIDTH-1:0] wdata_q;

    assign idx_next = idx + 8'd1;

    // In DMA_WR the write data is the byte captured on entry; otherwise the registered CPU data.
    assign mem_wdata = (state == DMA_WR) ? dma_data : wdata_q;

    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            odd       <= 1'b0;
            idx       <= 8'd0;
            page      <= '0;
            dma_data  <= '0;
            wdata_q   <= '0;
            mem_addr  <= '0;
            mem_wr    <= 1'b0;
            f_gnt     <= 1'b0;
            e_gnt     <= 1'b0;
            cpu_stall <= 1'b0;
            dma_busy  <= 1'b0;
        end else begin
            odd      <= ~odd;
            f_gnt    <= 1'b0;
            e_gnt    <= 1'b0;
            mem_addr <= '0;
            mem_wr   <= 1'b0;
            wdata_q  <= '0;
            case (state)
                IDLE: begin
                    if (e_req) begin
                        e_gnt <= 1'b1;
                        if (e_wr && (e_addr == DMA_TRIG)) begin
                            // Trigger write is swallowed: it only latches the source page.
                            page      <= e_wdata;
                            idx       <= 8'd0;
                            state     <= ALIGN;
                            cpu_stall <= 1'b1;
                            dma_busy  <= 1'b1;
                        end else begin
                            mem_addr <= e_addr;
                            mem_wr   <= e_wr;
                            wdata_q  <= e_wr ? e_wdata : '0;
                        end
                    end else if (f_req) begin
                        f_gnt    <= 1'b1;
                        mem_addr <= f_addr;
                    end
                end
                ALIGN: begin
                    if (odd) begin
                        state <= ALIGN2;
                    end else begin
                        state    <= DMA_RD;
                        mem_addr <= ADDR_WIDTH'({page, idx});
                    end
                end
                ALIGN2: begin
                    state    <= DMA_RD;
                    mem_addr <= ADDR_WIDTH'({page, idx});
                end
                DMA_RD: begin
                    state    <= DMA_WR;
                    dma_data <= mem_rdata;
                    mem_addr <= OAM_DATA;
                    mem_wr   <= 1'b1;
                end
                DMA_WR: begin
                    idx <= idx_next;
                    if (idx == 8'hFF) begin
                        state     <= IDLE;
                        cpu_stall <= 1'b0;
                        dma_busy  <= 1'b0;
                    end else begin
                        // idx wraps inside its own 8 bits, so the page byte is never disturbed.
                        state    <= DMA_RD;
                        mem_addr <= ADDR_WIDTH'({page, idx_next});
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a schedule-based reference model predicts every
// bus cycle, plus directed arbitration, DMA parity, page-FF and mid-DMA reset cases.
module tb_mem_arbiter;

    logic        phi1 = 1'b0;
    logic        reset = 1'b0;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        e_req = 1'b0;
    logic        e_wr = 1'b0;
    logic [15:0] e_addr = '0;
    logic [7:0]  e_wdata = '0;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic        f_gnt;
    logic        e_gnt;
    logic        cpu_stall;
    logic        dma_busy;

    mem_arbiter dut (
        .phi1      (phi1),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .e_req     (e_req),
        .e_wr      (e_wr),
        .e_addr    (e_addr),
        .e_wdata   (e_wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .f_gnt     (f_gnt),
        .e_gnt     (e_gnt),
        .cpu_stall (cpu_stall),
        .dma_busy  (dma_busy)
    );

    always #5 phi1 = ~phi1;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[3:0], a[15:12]} ^ a[11:4] ^ 8'hA5;
    endfunction

    always_comb mem_rdata = mem_byte(mem_addr);

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        logic        fg;
        logic        eg;
        logic        stall;
    } exp_t;

    exp_t sched[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edges   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_wr"}, 32'(mem_wr), 32'h0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
        chk({tag, "_fgnt"}, 32'(f_gnt), 32'h0);
        chk({tag, "_egnt"}, 32'(e_gnt), 32'h0);
        chk({tag, "_stall"}, 32'(cpu_stall), 32'h0);
        chk({tag, "_busy"}, 32'(dma_busy), 32'h0);
    endtask

    // One clock: predict the cycle following this edge from the inputs it saw, then compare.
    task automatic step();
        exp_t e;
        exp_t s;
        @(posedge phi1);
        edges++;
        e = '0;
        if (sched.size() > 0) begin
            e = sched.pop_front();
        end else if (e_req) begin
            e.eg = 1'b1;
            if (e_wr && e_addr == 16'h4014) begin
                e.stall = 1'b1;
                s = '0;
                s.stall = 1'b1;
                if (edges % 2 == 1) sched.push_back(s);
                for (int i = 0; i < 256; i++) begin
                    logic [15:0] a;
                    logic [7:0]  ib;
                    ib = 8'(i);
                    a  = {e_wdata, ib};
                    s = '0;
                    s.stall = 1'b1;
                    s.addr  = a;
                    sched.push_back(s);
                    s.addr  = 16'h2004;
                    s.wr    = 1'b1;
                    s.wdata = mem_byte(a);
                    sched.push_back(s);
                end
                sched.push_back('0);
            end else begin
                e.addr  = e_addr;
                e.wr    = e_wr;
                e.wdata = e_wr ? e_wdata : 8'h00;
            end
        end else if (f_req) begin
            e.fg   = 1'b1;
            e.addr = f_addr;
        end
        #1;
        chk("addr", 32'(mem_addr), 32'(e.addr));
        chk("wr", 32'(mem_wr), 32'(e.wr));
        chk("wdata", 32'(mem_wdata), 32'(e.wdata));
        chk("f_gnt", 32'(f_gnt), 32'(e.fg));
        chk("e_gnt", 32'(e_gnt), 32'(e.eg));
        chk("stall", 32'(cpu_stall), 32'(e.stall));
        chk("busy", 32'(dma_busy), 32'(e.stall));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        chk_zero(tag);
        @(posedge phi1);
        #1;
        chk_zero({tag, "_held"});
        reset = 1'b0;
        edges = 0;
        sched.delete();
    endtask

    task automatic idle_inputs();
        f_req = 1'b0; e_req = 1'b0; e_wr = 1'b0;
        f_addr = '0; e_addr = '0; e_wdata = '0;
    endtask

    task automatic random_inputs();
        f_req   = 1'($urandom_range(0, 1));
        f_addr  = 16'($urandom);
        e_req   = ($urandom_range(0, 2) == 0);
        e_wr    = 1'($urandom_range(0, 1));
        e_addr  = ($urandom_range(0, 7) == 0) ? 16'h4014 : 16'($urandom);
        e_wdata = 8'($urandom);
    endtask

    task automatic run_dma(input logic [7:0] pg, input bit want_odd, input bit hold_f,
                           output int cnt, output logic [15:0] last_rd);
        idle_inputs();
        if (((edges + 1) % 2) != int'(want_odd)) step();
        e_req = 1'b1; e_wr = 1'b1; e_addr = 16'h4014; e_wdata = pg;
        f_req = hold_f; f_addr = 16'h0ABC;
        step();
        chk("trig_wr", 32'(mem_wr), 32'h0);
        chk("trig_egnt", 32'(e_gnt), 32'h1);
        e_req = 1'b0;
        cnt = 0;
        last_rd = '0;
        for (int k = 0; k < 600 && cpu_stall; k++) begin
            if (!mem_wr && !e_gnt && mem_addr[15:8] == pg) last_rd = mem_addr;
            cnt++;
            step();
        end
        if (hold_f) begin
            step();
            chk("held_f_gnt", 32'(f_gnt), 32'h1);
            chk("held_f_addr", 32'(mem_addr), 32'h0ABC);
        end
    endtask

    initial begin
        int          cnt;
        logic [15:0] last_rd;
        logic [7:0]  pg;
        bit          found;

        #1;
        do_reset("reset");

        f_req = 1'b1; f_addr = 16'h8000;
        step();
        chk("f_only_gnt", 32'(f_gnt), 32'h1);
        chk("f_only_addr", 32'(mem_addr), 32'h8000);

        e_req = 1'b1; e_wr = 1'b1; e_addr = 16'h0010; e_wdata = 8'h5A;
        step();
        chk("both_egnt", 32'(e_gnt), 32'h1);
        chk("both_fgnt", 32'(f_gnt), 32'h0);
        chk("both_wdata", 32'(mem_wdata), 32'h5A);
        e_req = 1'b0;
        step();
        chk("f_after_gnt", 32'(f_gnt), 32'h1);

        e_req = 1'b1; e_wr = 1'b0; e_addr = 16'h4014; f_req = 1'b0;
        step();
        chk("trig_read_stall", 32'(cpu_stall), 32'h0);
        step();
        chk("trig_read_stall2", 32'(cpu_stall), 32'h0);

        run_dma(8'h02, 1'b0, 1'b1, cnt, last_rd);
        chk("even_stall_cycles", 32'(cnt), 32'd513);
        chk("even_last_rd", 32'(last_rd), 32'h02FF);

        pg = 8'($urandom);
        run_dma(pg, 1'b1, 1'b0, cnt, last_rd);
        chk("odd_stall_cycles", 32'(cnt), 32'd514);
        chk("odd_last_rd", 32'(last_rd), 32'({pg, 8'hFF}));

        run_dma(8'hFF, 1'b0, 1'b0, cnt, last_rd);
        chk("ff_stall_cycles", 32'(cnt), 32'd513);
        chk("ff_last_rd", 32'(last_rd), 32'hFFFF);

        for (int i = 0; i < 1500; i++) begin
            random_inputs();
            step();
        end

        idle_inputs();
        for (int i = 0; i < 600 && sched.size() > 0; i++) step();
        e_req = 1'b1; e_wr = 1'b1; e_addr = 16'h4014; e_wdata = 8'h37;
        step();
        e_req = 1'b0; f_req = 1'b1; f_addr = 16'h1234;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            if (cpu_stall && !mem_wr && mem_addr == 16'h3740) found = 1'b1;
        end
        chk("reach_idx40", 32'(found), 32'h1);
        #2;
        do_reset("mid_dma_reset");
        step();
        chk("post_reset_fgnt", 32'(f_gnt), 32'h1);
        chk("post_reset_addr", 32'(mem_addr), 32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
